// File: rtl/nb_rr_arbiter_if.sv
// One native-bus port: a write channel and a read channel, each a level
// request held until a one-cycle ack. The requester side uses "master",
// the responder side uses "slave".
interface nb_rr_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) ();
   logic              write_req;
   logic [ADDR_W-1:0] write_addr;
   logic [DATA_W-1:0] write_data;
   logic              write_ack;
   logic              read_req;
   logic [ADDR_W-1:0] read_addr;
   logic [DATA_W-1:0] read_data;
   logic              read_ack;

   modport master (
      output write_req, write_addr, write_data, read_req, read_addr,
      input  write_ack, read_data, read_ack
   );

   modport slave (
      input  write_req, write_addr, write_data, read_req, read_addr,
      output write_ack, read_data, read_ack
   );
endinterface

// File: rtl/nb_rr_arbiter.sv
// Two-master round-robin arbiter in front of apb_converter. One transfer
// outstanding at a time, write beats read within a master, and a watchdog
// that force-completes a hung transfer with an error pulse.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transfer; pick a master and latch its request
// ISSUE | downstream req held; wait for matching ack or watchdog expiry
// RESP  | one-cycle ack (and err on timeout) to the served master
// DRAIN | wait for a level downstream ack to fall before the next grant
module nb_rr_arbiter #(
   parameter int ADDR_W         = 8,
   parameter int DATA_W         = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic            clk,
   input  logic            resetn,
   nb_rr_arbiter_if.slave  m0,
   nb_rr_arbiter_if.slave  m1,
   nb_rr_arbiter_if.master dn,
   output logic            m0_err,
   output logic            m1_err
);

   localparam int WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WDOG_W-1:0] WDOG_LOAD =
      WDOG_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP, S_DRAIN} state_t;

   state_t            state;
   logic              last_gnt;
   logic              cur_id;
   logic              cur_wr;
   logic              mask_vld;
   logic              mask_id;
   logic [WDOG_W-1:0] wdog;

   logic              elig0, elig1, gnt, gnt_vld, g_wr;
   logic              ack_match, wdog_tc, timed_out;
   logic [ADDR_W-1:0] g_waddr, g_raddr;
   logic [DATA_W-1:0] g_wdata, rsp_data;

   // Grant selection, completion detect and the watchdog terminal count.
   always_comb begin
      elig0   = (m0.write_req | m0.read_req) & ~(mask_vld & ~mask_id);
      elig1   = (m1.write_req | m1.read_req) & ~(mask_vld &  mask_id);
      gnt_vld = elig0 | elig1;
      // Both eligible: the one not served last. Otherwise whichever asks.
      gnt     = (elig0 & elig1) ? ~last_gnt : ~elig0;
      g_wr    = gnt ? m1.write_req  : m0.write_req;
      g_waddr = gnt ? m1.write_addr : m0.write_addr;
      g_wdata = gnt ? m1.write_data : m0.write_data;
      g_raddr = gnt ? m1.read_addr  : m0.read_addr;
      ack_match = cur_wr ? dn.write_ack : dn.read_ack;
      wdog_tc   = WDOG_EN && (wdog == '0);
      // An ack arriving on the expiry cycle still counts as a clean finish.
      timed_out = ~ack_match & wdog_tc;
      rsp_data  = ack_match ? dn.read_data : '1;
   end

   // Sequencer with registered downstream requests and upstream responses.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state         <= S_IDLE;
         last_gnt      <= 1'b1;
         cur_id        <= 1'b0;
         cur_wr        <= 1'b0;
         mask_vld      <= 1'b0;
         mask_id       <= 1'b0;
         wdog          <= '0;
         dn.write_req  <= 1'b0;
         dn.write_addr <= '0;
         dn.write_data <= '0;
         dn.read_req   <= 1'b0;
         dn.read_addr  <= '0;
         m0.write_ack  <= 1'b0;
         m0.read_ack   <= 1'b0;
         m0.read_data  <= '0;
         m1.write_ack  <= 1'b0;
         m1.read_ack   <= 1'b0;
         m1.read_data  <= '0;
         m0_err        <= 1'b0;
         m1_err        <= 1'b0;
      end else begin
         m0.write_ack <= 1'b0;
         m0.read_ack  <= 1'b0;
         m1.write_ack <= 1'b0;
         m1.read_ack  <= 1'b0;
         m0_err       <= 1'b0;
         m1_err       <= 1'b0;
         mask_vld     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (gnt_vld) begin
                  cur_id       <= gnt;
                  cur_wr       <= g_wr;
                  last_gnt     <= gnt;
                  dn.write_req <= g_wr;
                  dn.read_req  <= ~g_wr;
                  if (g_wr) begin
                     dn.write_addr <= g_waddr;
                     dn.write_data <= g_wdata;
                  end else begin
                     dn.read_addr  <= g_raddr;
                  end
                  wdog  <= WDOG_LOAD;
                  state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (ack_match || wdog_tc) begin
                  dn.write_req <= 1'b0;
                  dn.read_req  <= 1'b0;
                  if (cur_id) begin
                     m1.write_ack <= cur_wr;
                     m1.read_ack  <= ~cur_wr;
                     m1_err       <= timed_out;
                     if (!cur_wr) m1.read_data <= rsp_data;
                  end else begin
                     m0.write_ack <= cur_wr;
                     m0.read_ack  <= ~cur_wr;
                     m0_err       <= timed_out;
                     if (!cur_wr) m0.read_data <= rsp_data;
                  end
                  state <= S_RESP;
               end else begin
                  wdog <= wdog - 1'b1;
               end
            end
            S_RESP: begin
               if (dn.write_ack || dn.read_ack) begin
                  state <= S_DRAIN;
               end else begin
                  // The served master may still show its request this cycle.
                  mask_vld <= 1'b1;
                  mask_id  <= cur_id;
                  state    <= S_IDLE;
               end
            end
            S_DRAIN: begin
               if (!dn.write_ack && !dn.read_ack) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nb_rr_arbiter.sv
// Randomized bench for nb_rr_arbiter: a transaction-level model of the two
// masters and a memory-backed downstream responder, checked every cycle.
module tb_nb_rr_arbiter;

   logic clk;
   logic resetn;
   logic m0_err, m1_err;

   nb_rr_arbiter_if #(.ADDR_W(8), .DATA_W(8)) m0_if ();
   nb_rr_arbiter_if #(.ADDR_W(8), .DATA_W(8)) m1_if ();
   nb_rr_arbiter_if #(.ADDR_W(8), .DATA_W(8)) dn_if ();

   nb_rr_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(8)) dut (
      .clk    (clk),
      .resetn (resetn),
      .m0     (m0_if),
      .m1     (m1_if),
      .dn     (dn_if),
      .m0_err (m0_err),
      .m1_err (m1_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // requester side
   logic       req_w[2], req_r[2];
   logic [7:0] waddr[2], wdata[2], raddr[2];
   bit         pend_w[2], pend_r[2];
   bit         drop_w_late[2], drop_r_late[2];
   int         refill[2];
   logic [7:0] exp_rd[2];
   int         last_served;
   logic [7:0] served_seq;

   // responder side
   logic       dn_wack, dn_rack;
   logic [7:0] dn_rdata, drv_rdata;
   logic [7:0] mem[256];
   bit         busy, cur_wr, hang, hold_ack, hold_wr;
   int         cur_m, cnt, lat, force_lat;
   bit         force_hang;
   logic [7:0] cur_addr;
   logic [25:0] cur_v;

   int n_chk, n_pass;

   assign m0_if.write_req  = req_w[0];
   assign m0_if.write_addr = waddr[0];
   assign m0_if.write_data = wdata[0];
   assign m0_if.read_req   = req_r[0];
   assign m0_if.read_addr  = raddr[0];
   assign m1_if.write_req  = req_w[1];
   assign m1_if.write_addr = waddr[1];
   assign m1_if.write_data = wdata[1];
   assign m1_if.read_req   = req_r[1];
   assign m1_if.read_addr  = raddr[1];
   assign dn_if.write_ack  = dn_wack;
   assign dn_if.read_ack   = dn_rack;
   assign dn_if.read_data  = dn_rdata;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic logic [63:0] all_outs();
      return {16'h0, dn_if.write_req, dn_if.read_req, dn_if.write_addr, dn_if.write_data,
              dn_if.read_addr, m0_if.write_ack, m0_if.read_ack, m0_err,
              m1_if.write_ack, m1_if.read_ack, m1_err, m0_if.read_data, m1_if.read_data};
   endfunction

   // Round robin over masters with something outstanding.
   function automatic int exp_grant();
      bit e0, e1;
      e0 = pend_w[0] | pend_r[0];
      e1 = pend_w[1] | pend_r[1];
      if (e0 && e1) return (last_served == 0) ? 1 : 0;
      if (e0) return 0;
      if (e1) return 1;
      return -1;
   endfunction

   function automatic bit any_pend();
      return pend_w[0] | pend_r[0] | pend_w[1] | pend_r[1];
   endfunction

   task automatic post(input int n, input bit w, input bit r);
      if (w) begin
         pend_w[n] = 1'b1;
         waddr[n]  = 8'(n * 128 + $urandom_range(0, 3));
         wdata[n]  = 8'($urandom);
         req_w[n]  = 1'b1;
      end
      if (r) begin
         pend_r[n] = 1'b1;
         raddr[n]  = 8'(n * 128 + $urandom_range(0, 3));
         req_r[n]  = 1'b1;
      end
   endtask

   task automatic step();
      logic [5:0]  ackv, expv;
      logic [25:0] dnv, dnexp;
      int          em;
      bit          late;
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
         if (drop_w_late[n]) begin req_w[n] = 1'b0; drop_w_late[n] = 1'b0; end
         if (drop_r_late[n]) begin req_r[n] = 1'b0; drop_r_late[n] = 1'b0; end
      end
      ackv = {m0_if.write_ack, m0_if.read_ack, m0_err, m1_if.write_ack, m1_if.read_ack, m1_err};
      expv = '0;
      dnv  = {dn_if.write_req, dn_if.read_req,
              dn_if.write_req ? dn_if.write_addr : 8'h00,
              dn_if.write_req ? dn_if.write_data : 8'h00,
              dn_if.read_req  ? dn_if.read_addr  : 8'h00};
      if (!busy) begin
         if (dnv[25:24] != 2'b00) begin
            em    = exp_grant();
            dnexp = '0;
            if (em >= 0) begin
               if (pend_w[em]) dnexp = {2'b10, waddr[em], wdata[em], 8'h00};
               else            dnexp = {2'b01, 16'h0000, raddr[em]};
            end
            chk("grant", dnv, dnexp);
            busy        = 1'b1;
            cur_m       = (em < 0) ? 0 : em;
            cur_wr      = dnv[25];
            cur_v       = dnv;
            cur_addr    = cur_wr ? dnv[23:16] : dnv[7:0];
            cnt         = 1;
            last_served = cur_m;
            served_seq  = {served_seq[6:0], cur_m[0]};
            if (force_lat >= 0) begin
               lat  = force_lat;
               hang = force_hang;
            end else begin
               hang = ($urandom_range(0, 7) == 0);
               lat  = hang ? 7 : $urandom_range(0, 7);
            end
         end
      end else if (dnv[25:24] != 2'b00) begin
         cnt++;
         chk("hold", dnv, cur_v);
      end else begin
         chk("issue_len", cnt, hang ? 8 : lat + 1);
         expv = (cur_m == 0) ? {cur_wr, ~cur_wr, hang, 3'b000} : {3'b000, cur_wr, ~cur_wr, hang};
         late = ($urandom_range(0, 1) == 1);
         if (cur_wr) begin
            if (!hang) mem[cur_addr] = cur_v[15:8];
            pend_w[cur_m] = 1'b0;
            if (refill[cur_m] > 0) begin
               refill[cur_m]--;
               post(cur_m, 1'b1, 1'b0);
            end else if (late) drop_w_late[cur_m] = 1'b1;
            else req_w[cur_m] = 1'b0;
         end else begin
            exp_rd[cur_m] = hang ? 8'hFF : drv_rdata;
            pend_r[cur_m] = 1'b0;
            if (late) drop_r_late[cur_m] = 1'b1;
            else req_r[cur_m] = 1'b0;
         end
         busy = 1'b0;
      end
      chk("acks", ackv, expv);
      chk("rdata0", m0_if.read_data, exp_rd[0]);
      chk("rdata1", m1_if.read_data, exp_rd[1]);
      // downstream drive for the next edge
      dn_wack  = 1'b0;
      dn_rack  = 1'b0;
      dn_rdata = 8'($urandom);
      if (hold_ack) begin
         hold_ack = 1'b0;
         if (hold_wr) dn_wack = 1'b1;
         else         dn_rack = 1'b1;
      end
      if (busy) begin
         if (!hang && cnt == lat + 1) begin
            if (cur_wr) dn_wack = 1'b1;
            else begin
               dn_rack   = 1'b1;
               dn_rdata  = mem[cur_addr];
               drv_rdata = dn_rdata;
            end
            hold_ack = ($urandom_range(0, 3) == 0);
            hold_wr  = cur_wr;
         end else if (cnt == 1 && lat >= 2 && $urandom_range(0, 1) == 1) begin
            if (cur_wr) dn_rack = 1'b1;
            else        dn_wack = 1'b1;
         end
      end
   endtask

   task automatic run_round();
      int guard;
      guard = 0;
      do begin
         step();
         guard++;
      end while ((busy || any_pend()) && guard < 300);
      if (guard >= 300) chk("round_bound", {busy, pend_w[0], pend_r[0], pend_w[1], pend_r[1]}, 0);
      step(); step(); step();
   endtask

   task automatic model_reset();
      for (int n = 0; n < 2; n++) begin
         req_w[n] = 1'b0; req_r[n] = 1'b0;
         pend_w[n] = 1'b0; pend_r[n] = 1'b0;
         drop_w_late[n] = 1'b0; drop_r_late[n] = 1'b0;
         refill[n] = 0;
         exp_rd[n] = 8'h00;
      end
      last_served = 1;
      busy = 1'b0; hold_ack = 1'b0;
      dn_wack = 1'b0; dn_rack = 1'b0;
      force_lat = -1; force_hang = 1'b0;
   endtask

   initial begin
      n_chk = 0; n_pass = 0;
      served_seq = '0;
      dn_rdata = '0; drv_rdata = '0;
      waddr[0] = '0; waddr[1] = '0; wdata[0] = '0; wdata[1] = '0;
      raddr[0] = '0; raddr[1] = '0;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h3C);
      model_reset();
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset", all_outs(), 64'h0);
      resetn = 1'b1;
      step();

      // single m0 write
      pend_w[0] = 1'b1; waddr[0] = 8'hCC; wdata[0] = 8'hAC; req_w[0] = 1'b1;
      force_lat = 2; force_hang = 1'b0;
      step();
      chk("req_lat", dn_if.write_req, 1'b1);
      run_round();
      force_lat = -1;

      // m1 write then read of the same address
      pend_w[1] = 1'b1; waddr[1] = 8'h10; wdata[1] = 8'h5A; req_w[1] = 1'b1;
      run_round();
      pend_r[1] = 1'b1; raddr[1] = 8'h10; req_r[1] = 1'b1;
      run_round();
      chk("wr_rd", m1_if.read_data, 8'h5A);

      // contention: four writes each, kept requesting
      served_seq = '0;
      refill[0] = 3; refill[1] = 3;
      post(0, 1'b1, 1'b0); post(1, 1'b1, 1'b0);
      run_round();
      chk("order", served_seq, 8'b01010101);

      // write and read together on m0
      post(0, 1'b1, 1'b1);
      run_round();

      // m0 read with no downstream ack
      force_lat = 7; force_hang = 1'b1;
      post(0, 1'b0, 1'b1);
      run_round();
      chk("to_data", m0_if.read_data, 8'hFF);

      // ack on the last watchdog cycle wins
      force_hang = 1'b0;
      post(1, 1'b1, 1'b0);
      run_round();
      force_lat = -1;

      // reset during ISSUE
      force_lat = 7; force_hang = 1'b1;
      post(0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step();
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      model_reset();
      chk("rst_mid", all_outs(), 64'h0);
      served_seq = '0;
      post(0, 1'b1, 1'b0); post(1, 1'b1, 1'b0);
      run_round();
      chk("rst_tie", served_seq[1:0], 2'b01);

      // random traffic
      for (int r = 0; r < 80; r++) begin
         for (int n = 0; n < 2; n++)
            post(n, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
         run_round();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
